// File: rtl/usb_in_pkt_ring.sv
// Multi-slot IN packet ring between application fill logic and the USB protocol engine.
// The application fills and commits slots while earlier packets wait for host transmission.
module usb_in_pkt_ring #(
  parameter int DATA_W    = 8,
  parameter int MAX_PKT   = 512,
  parameter int NUM_SLOTS = 4,
  parameter int ADDR_W    = $clog2(MAX_PKT),
  parameter int LEN_W     = ADDR_W + 1,
  parameter int CNT_W     = $clog2(NUM_SLOTS) + 1
) (
  input  logic              phy_ulpi_clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] buf_in_addr,
  input  logic [DATA_W-1:0] buf_in_data,
  input  logic              buf_in_wren,
  output logic              buf_in_ready,
  input  logic              buf_in_commit,
  input  logic [LEN_W-1:0]  buf_in_commit_len,
  output logic              buf_in_commit_ack,
  input  logic              buf_in_flush,
  input  logic [ADDR_W-1:0] pkt_rd_addr,
  output logic [DATA_W-1:0] pkt_rd_q,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              pkt_hasdata,
  output logic              pkt_zlp,
  input  logic              pkt_done,
  output logic [CNT_W-1:0]  occupancy,
  output logic              err_overflow,
  output logic              err_len
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int DEPTH  = NUM_SLOTS * MAX_PKT;

  logic [SLOT_W-1:0] wr_slot;
  logic [SLOT_W-1:0] rd_slot;
  logic [CNT_W-1:0]  count;
  logic [LEN_W-1:0]  len_q [NUM_SLOTS];
  logic [DATA_W-1:0] mem   [DEPTH];

  logic ready;
  logic hasdata;
  logic wr_ok;
  logic commit_take;
  logic len_bad;
  logic commit_ok;
  logic done_ok;

  always_comb begin
    ready       = (count != CNT_W'(NUM_SLOTS));
    hasdata     = (count != '0);
    len_bad     = (buf_in_commit_len > LEN_W'(MAX_PKT));
    wr_ok       = buf_in_wren & ready & ~buf_in_flush;
    commit_take = buf_in_commit & ready & ~buf_in_flush;
    commit_ok   = commit_take & ~len_bad;
    done_ok     = pkt_done & hasdata & ~buf_in_flush;
  end

  // Packet storage carries no reset; only the read register is cleared.
  always_ff @(posedge phy_ulpi_clk) begin
    if (wr_ok) mem[{wr_slot, buf_in_addr}] <= buf_in_data;
  end

  always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
    if (!reset_n) pkt_rd_q <= '0;
    else          pkt_rd_q <= mem[{rd_slot, pkt_rd_addr}];
  end

  always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_slot           <= '0;
      rd_slot           <= '0;
      count             <= '0;
      buf_in_commit_ack <= 1'b0;
      err_overflow      <= 1'b0;
      err_len           <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) len_q[i] <= '0;
    end else begin
      buf_in_commit_ack <= 1'b0;
      if (buf_in_flush) begin
        wr_slot      <= '0;
        rd_slot      <= '0;
        count        <= '0;
        err_overflow <= 1'b0;
        err_len      <= 1'b0;
      end else begin
        if ((buf_in_wren | buf_in_commit) & ~ready) err_overflow <= 1'b1;
        // An oversize commit is acknowledged but leaves the slot open for refill.
        if (commit_take) begin
          buf_in_commit_ack <= 1'b1;
          if (len_bad) begin
            err_len <= 1'b1;
          end else begin
            len_q[wr_slot] <= buf_in_commit_len;
            wr_slot        <= wr_slot + 1'b1;
          end
        end
        if (done_ok) rd_slot <= rd_slot + 1'b1;
        case ({commit_ok, done_ok})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_comb begin
    buf_in_ready = ready;
    pkt_hasdata  = hasdata;
    pkt_len      = hasdata ? len_q[rd_slot] : '0;
    pkt_zlp      = hasdata & (pkt_len == '0);
    occupancy    = count;
  end

endmodule

// File: tb/tb_usb_in_pkt_ring.sv
// Directed, table-driven bench for usb_in_pkt_ring with hand-written multi-cycle sequences.
module tb_usb_in_pkt_ring;

  localparam int DATA_W    = 8;
  localparam int MAX_PKT   = 512;
  localparam int NUM_SLOTS = 4;
  localparam int ADDR_W    = 9;
  localparam int LEN_W     = 10;
  localparam int CNT_W     = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic              ready;
  logic              commit;
  logic [LEN_W-1:0]  clen;
  logic              ack;
  logic              flush;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_q;
  logic [LEN_W-1:0]  plen;
  logic              hasdata;
  logic              zlp;
  logic              done;
  logic [CNT_W-1:0]  occ;
  logic              eovf;
  logic              elen;

  int passed = 0;
  int total  = 0;

  usb_in_pkt_ring #(
    .DATA_W   (DATA_W),
    .MAX_PKT  (MAX_PKT),
    .NUM_SLOTS(NUM_SLOTS)
  ) dut (
    .phy_ulpi_clk     (clk),
    .reset_n          (rst_n),
    .buf_in_addr      (addr),
    .buf_in_data      (data),
    .buf_in_wren      (wren),
    .buf_in_ready     (ready),
    .buf_in_commit    (commit),
    .buf_in_commit_len(clen),
    .buf_in_commit_ack(ack),
    .buf_in_flush     (flush),
    .pkt_rd_addr      (rd_addr),
    .pkt_rd_q         (rd_q),
    .pkt_len          (plen),
    .pkt_hasdata      (hasdata),
    .pkt_zlp          (zlp),
    .pkt_done         (done),
    .occupancy        (occ),
    .err_overflow     (eovf),
    .err_len          (elen)
  );

  always #5 clk = ~clk;

  typedef struct {
    int wren, addr, data, commit, clen, done, flush, rd_addr, rq_chk, rq;
    int ack, rdy, hd, len, zlp, occ, ovf, elen;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wren = 0; addr = '0; data = '0; commit = 0; clen = '0;
    done = 0; flush = 0; rd_addr = '0;
  endtask

  task automatic chk_status(input string tag, input int e_ack, input int e_rdy,
                            input int e_hd, input int e_len, input int e_zlp,
                            input int e_occ, input int e_ovf, input int e_elen);
    chk({tag, "_ack"}, int'(ack), e_ack);
    chk({tag, "_ready"}, int'(ready), e_rdy);
    chk({tag, "_hasdata"}, int'(hasdata), e_hd);
    chk({tag, "_len"}, int'(plen), e_len);
    chk({tag, "_zlp"}, int'(zlp), e_zlp);
    chk({tag, "_occ"}, int'(occ), e_occ);
    chk({tag, "_err_ovf"}, int'(eovf), e_ovf);
    chk({tag, "_err_len"}, int'(elen), e_elen);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_status("reset", 0, 1, 0, 0, 0, 0, 0, 0);
    chk("reset_rd_q", int'(rd_q), 0);

    // wren addr data commit clen done flush rd_addr rq_chk rq | ack rdy hd len zlp occ ovf elen
    vecs.push_back('{1, 0, 'hA0, 0, 0, 0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 1, 'hA1, 0, 0, 0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 2, 'hA2, 0, 0, 0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 3, 'hA3, 0, 0, 0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0,    1, 4, 0, 0, 0, 0, 0,     1, 1, 1, 4, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0,    0, 0, 0, 0, 0, 1, 'hA0,  0, 1, 1, 4, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0,    0, 0, 0, 0, 1, 1, 'hA1,  0, 1, 1, 4, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0,    0, 0, 0, 0, 2, 1, 'hA2,  0, 1, 1, 4, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0,    0, 0, 0, 0, 3, 1, 'hA3,  0, 1, 1, 4, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0,    0, 0, 1, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 'h11, 1, 1, 0, 0, 0, 0, 0,     1, 1, 1, 1, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 'h12, 1, 2, 0, 0, 0, 0, 0,     1, 1, 1, 1, 0, 2, 0, 0});
    vecs.push_back('{1, 0, 'h13, 1, 3, 0, 0, 0, 0, 0,     1, 1, 1, 1, 0, 3, 0, 0});
    vecs.push_back('{1, 0, 'h14, 1, 4, 0, 0, 0, 0, 0,     1, 0, 1, 1, 0, 4, 0, 0});
    vecs.push_back('{1, 0, 'hEE, 1, 1, 0, 0, 0, 1, 'h11,  0, 0, 1, 1, 0, 4, 1, 0});
    vecs.push_back('{0, 0, 0,    0, 0, 1, 0, 0, 1, 'h11,  0, 1, 1, 2, 0, 3, 1, 0});
    vecs.push_back('{0, 0, 0,    0, 0, 0, 0, 0, 1, 'h12,  0, 1, 1, 2, 0, 3, 1, 0});
    vecs.push_back('{0, 0, 0,    0, 0, 1, 0, 0, 0, 0,     0, 1, 1, 3, 0, 2, 1, 0});
    vecs.push_back('{0, 0, 0,    0, 0, 1, 0, 0, 0, 0,     0, 1, 1, 4, 0, 1, 1, 0});
    vecs.push_back('{0, 0, 0,    0, 0, 1, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 1, 0});
    vecs.push_back('{0, 0, 0,    1, 0, 0, 0, 0, 0, 0,     1, 1, 1, 0, 1, 1, 1, 0});
    vecs.push_back('{0, 0, 0,    0, 0, 1, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 1, 0});
    vecs.push_back('{0, 0, 0,    0, 0, 0, 1, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0, 0});

    foreach (vecs[i]) begin
      wren    = vecs[i].wren[0];
      addr    = ADDR_W'(vecs[i].addr);
      data    = DATA_W'(vecs[i].data);
      commit  = vecs[i].commit[0];
      clen    = LEN_W'(vecs[i].clen);
      done    = vecs[i].done[0];
      flush   = vecs[i].flush[0];
      rd_addr = ADDR_W'(vecs[i].rd_addr);
      tick();
      chk_status($sformatf("v%0d", i), vecs[i].ack, vecs[i].rdy, vecs[i].hd,
                 vecs[i].len, vecs[i].zlp, vecs[i].occ, vecs[i].ovf, vecs[i].elen);
      if (vecs[i].rq_chk != 0) chk($sformatf("v%0d_rd_q", i), int'(rd_q), vecs[i].rq);
    end
    idle();

    // Oversize commit: acked, flagged, slot stays open; then a MAX_PKT commit is taken.
    commit = 1; clen = LEN_W'(MAX_PKT + 1);
    tick();
    chk_status("len_bad", 1, 1, 0, 0, 0, 0, 0, 1);
    idle();
    tick();
    chk("len_bad_ack_drop", int'(ack), 0);
    commit = 1; clen = LEN_W'(MAX_PKT);
    tick();
    chk_status("len_max", 1, 1, 1, MAX_PKT, 0, 1, 0, 1);
    idle(); done = 1;
    tick();
    chk("len_max_drain_occ", int'(occ), 0);
    idle();

    // Commit and done together at occupancy 2.
    commit = 1; clen = 5; tick();
    commit = 1; clen = 6; tick();
    chk("sim_pre_occ", int'(occ), 2);
    chk("sim_pre_len", int'(plen), 5);
    commit = 1; clen = 7; done = 1;
    tick();
    chk_status("sim", 1, 1, 1, 6, 0, 2, 0, 1);
    idle(); done = 1; tick();
    chk("sim_d1_len", int'(plen), 7);
    tick();
    chk("sim_d2_occ", int'(occ), 0);
    idle();

    // Three trips round the ring with per-packet data.
    for (int p = 0; p < 3 * NUM_SLOTS; p++) begin
      for (int k = 0; k < 3; k++) begin
        wren = 1; addr = ADDR_W'(k); data = DATA_W'(p * 8 + k);
        tick();
      end
      idle();
      commit = 1; clen = LEN_W'(p % 3 + 1);
      tick();
      chk($sformatf("wrap%0d_len", p), int'(plen), p % 3 + 1);
      idle();
      for (int k = 0; k <= p % 3; k++) begin
        rd_addr = ADDR_W'(k);
        tick();
        chk($sformatf("wrap%0d_rd%0d", p, k), int'(rd_q), p * 8 + k);
      end
      idle(); done = 1;
      tick();
      chk($sformatf("wrap%0d_occ", p), int'(occ), 0);
      idle();
    end

    // Flush with a simultaneous commit at occupancy 3.
    commit = 1; clen = 600; tick();
    commit = 1; clen = 1; tick();
    commit = 1; clen = 2; tick();
    commit = 1; clen = 3; tick();
    chk("flush_pre_occ", int'(occ), 3);
    chk("flush_pre_elen", int'(elen), 1);
    commit = 1; clen = 4; flush = 1; wren = 1; data = 8'h5A;
    tick();
    chk_status("flush", 0, 1, 0, 0, 0, 0, 0, 0);
    idle();

    // Asynchronous reset in the middle of a packet fill.
    wren = 1; addr = '0; data = 8'hA5; tick();
    idle(); commit = 1; clen = 1; tick();
    idle(); rd_addr = '0; tick();
    chk("rst_pre_rd_q", int'(rd_q), 'hA5);
    chk("rst_pre_occ", int'(occ), 1);
    wren = 1; addr = 1; data = 8'h77;
    #3 rst_n = 1'b0;
    #1;
    chk_status("async_rst", 0, 1, 0, 0, 0, 0, 0, 0);
    chk("async_rst_rd_q", int'(rd_q), 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_occ", int'(occ), 0);
    chk("post_rst_hasdata", int'(hasdata), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
